stopwatch_ctrl: RTL

Run-control sequencer for the stopwatch datapath. It takes the two raw, active-low push-buttons and the 50 MHz board clock, and debounces both buttons. A start/stop/lap/clear state machine then produces the signals that drive the BCD counter chain and the display path:

- the 100 Hz count-enable tick
- a synchronous clear pulse
- a lap-hold (display freeze) level

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/key_debounce.sv | 60 ++++++
 rtl/stopwatch_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and sizing helpers for the stopwatch run-control block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2,
        StLap    = 2'd3
    } sw_state_e;

    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of a counter that holds 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes one raw active-low push-button, filters bounce, and emits a
// one-cycle press event one cycle after the debounced level falls.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            level_dly_q;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample, or an accepted change, restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        press_d = level_dly_q & ~level_q;
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear sequencer: debounced keys drive a four-state FSM and a
// tick divider that pauses without losing the fractional count.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    output logic       tick,
    output logic       clear,
    output logic       hold,
    output logic [1:0] state
);

    localparam int unsigned TickDiv = tick_div(CLK_HZ, TICK_HZ);
    localparam int unsigned DivW    = cnt_width(TickDiv);
    localparam logic [DivW-1:0] DivLast = DivW'(TickDiv - 1);

    sw_state_e       state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic            tick_q, tick_d;
    logic            clear_q, clear_d;
    logic            hold_q, hold_d;
    logic            start_ev, lap_ev, lap_only;
    logic            run_now, run_next;
    logic            unused_start_level, unused_lap_level;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_start (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .key_n   (key_start_n),
        .level   (unused_start_level),
        .press   (start_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_lap (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .key_n   (key_lap_n),
        .level   (unused_lap_level),
        .press   (lap_ev)
    );

    // Start has priority when both events land in the same cycle.
    assign lap_only = lap_ev & ~start_ev;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            div_q   <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ev) state_d = StRun;
            end
            StRun: begin
                if (start_ev)    state_d = StPaused;
                else if (lap_ev) state_d = StLap;
            end
            StPaused: begin
                if (start_ev)    state_d = StRun;
                else if (lap_ev) state_d = StIdle;
            end
            StLap: begin
                if (start_ev)    state_d = StPaused;
                else if (lap_ev) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        run_now  = (state_q == StRun) || (state_q == StLap);
        run_next = (state_d == StRun) || (state_d == StLap);

        div_d = div_q;
        if (run_now) begin
            div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
        end
        if ((state_q == StIdle && start_ev) || (state_q == StPaused && lap_only)) begin
            div_d = '0;
        end

        // A wrap coinciding with a move to PAUSED is dropped, not deferred.
        tick_d  = run_now && run_next && (div_q == DivLast);
        clear_d = lap_only && (state_q == StIdle || state_q == StPaused);
        hold_d  = (state_d == StLap);
    end

    assign state = state_q;
    assign tick  = tick_q;
    assign clear = clear_q;
    assign hold  = hold_q;

endmodule
